// File: rtl/sram_ctrl_pkg.sv
// Shared constants for sram_ctrl: FSM state encodings, SRAM word-address width, byte-select values.
package sram_ctrl_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_WREC  = 3'd3;
  localparam logic [2:0] ST_ACK   = 3'd4;

  localparam int         WORD_AW  = 20;

  localparam logic [3:0] SEL_ZERO = 4'b0000;
  localparam logic [3:0] BE_NONE  = 4'b1111;

endpackage

// File: rtl/sram_ctrl.sv
// Single-beat async SRAM controller; read ack at +WAIT_CYCLES+2, write +WAIT_CYCLES+3, empty-sel write +1.
// One request in flight: ce_i is only sampled in IDLE, all SRAM pins come straight from flops.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce_i,
  input  logic               we_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        data_i,
  input  logic [3:0]         sel_i,
  output logic [31:0]        data_o,
  output logic               ack_o,
  output logic [WORD_AW-1:0] sram_addr_o,
  output logic [31:0]        sram_dq_o,
  input  logic [31:0]        sram_dq_i,
  output logic               sram_dq_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [3:0]         sram_be_n
);

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

  logic [2:0]         r_state;
  logic [2:0]         r_wait;
  logic [WORD_AW-1:0] r_addr;
  logic [31:0]        r_data;
  logic [31:0]        r_rdata;
  logic               r_ack;
  logic               r_dq_oe;
  logic               r_ce_n;
  logic               r_oe_n;
  logic               r_we_n;
  logic [3:0]         r_be_n;

  logic               w_wait_done;
  logic               w_unused_addr;

  assign w_wait_done   = (r_wait == 3'd0);
  assign w_unused_addr = ^{addr_i[31:22], addr_i[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_wait  <= 3'd0;
      r_addr  <= '0;
      r_data  <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_dq_oe <= 1'b0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_be_n  <= BE_NONE;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (ce_i) begin
            r_addr <= addr_i[21:2];
            r_data <= data_i;
            if (!we_i) begin
              r_state <= ST_READ;
              r_wait  <= WAIT_INIT;
              r_ce_n  <= 1'b0;
              r_oe_n  <= 1'b0;
              r_be_n  <= SEL_ZERO;
            end else if (sel_i != SEL_ZERO) begin
              r_state <= ST_WRITE;
              r_wait  <= WAIT_INIT;
              r_ce_n  <= 1'b0;
              r_we_n  <= 1'b0;
              r_be_n  <= ~sel_i;
              r_dq_oe <= 1'b1;
            end else begin
              // Nothing to store: skip the SRAM cycle entirely.
              r_state <= ST_ACK;
              r_ack   <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (w_wait_done) begin
            r_rdata <= sram_dq_i;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_be_n  <= BE_NONE;
            r_state <= ST_ACK;
            r_ack   <= 1'b1;
          end else begin
            r_wait <= r_wait - 3'd1;
          end
        end
        ST_WRITE: begin
          if (w_wait_done) begin
            // Release WE first; address, data and CE stay one more cycle for hold time.
            r_we_n  <= 1'b1;
            r_state <= ST_WREC;
          end else begin
            r_wait <= r_wait - 3'd1;
          end
        end
        ST_WREC: begin
          r_ce_n  <= 1'b1;
          r_dq_oe <= 1'b0;
          r_be_n  <= BE_NONE;
          r_state <= ST_ACK;
          r_ack   <= 1'b1;
        end
        ST_ACK: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_wait  <= 3'd0;
          r_dq_oe <= 1'b0;
          r_ce_n  <= 1'b1;
          r_oe_n  <= 1'b1;
          r_we_n  <= 1'b1;
          r_be_n  <= BE_NONE;
        end
      endcase
    end
  end

  assign data_o      = r_rdata;
  assign ack_o       = r_ack;
  assign sram_addr_o = r_addr;
  assign sram_dq_o   = r_data;
  assign sram_dq_oe  = r_dq_oe;
  assign sram_ce_n   = r_ce_n;
  assign sram_oe_n   = r_oe_n;
  assign sram_we_n   = r_we_n;
  assign sram_be_n   = r_be_n;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: async SRAM pin model, word-level reference memory, queued expectations checked on ack_o.
`timescale 1ns/1ps
module tb_sram_ctrl;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] data_i = '0;
  logic [3:0]  sel_i = '0;
  logic [31:0] data_o;
  logic        ack_o;
  logic [19:0] sram_addr_o;
  logic [31:0] sram_dq_o;
  logic [31:0] sram_dq_i = '0;
  logic        sram_dq_oe;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [3:0]  sram_be_n;

  sram_ctrl #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .we_i(we_i), .addr_i(addr_i),
    .data_i(data_i), .sel_i(sel_i), .data_o(data_o), .ack_o(ack_o),
    .sram_addr_o(sram_addr_o), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  always #5 clk = ~clk;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memories start from a deterministic per-address pattern.
  function automatic logic [31:0] init_word(input logic [19:0] a);
    return {a[11:0], 20'hA5C3F ^ a};
  endfunction

  logic [31:0] sram_mem [bit [19:0]];
  logic [31:0] ref_mem  [bit [19:0]];

  function automatic logic [31:0] sram_rd(input logic [19:0] a);
    return sram_mem.exists(a) ? sram_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [19:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // SRAM device: stores while CE/WE are low, drives read data while CE/OE are low.
  logic [31:0] sm_w;
  always @(negedge clk) begin
    if (!sram_ce_n && !sram_we_n) begin
      sm_w = sram_rd(sram_addr_o);
      for (int b = 0; b < 4; b++)
        if (!sram_be_n[b]) sm_w[8*b +: 8] = sram_dq_o[8*b +: 8];
      sram_mem[sram_addr_o] = sm_w;
    end
    sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_rd(sram_addr_o) : 32'hBAD0BAD0;
  end

  typedef struct {
    int unsigned ack_cyc;
    logic [31:0] data_o;
    int          ce_cnt;
    int          oe_cnt;
    int          we_cnt;
    int          dqoe_cnt;
    logic [19:0] addr;
    logic [3:0]  be_n;
    logic [31:0] dq;
  } exp_t;

  exp_t exp_q[$];

  int          ce_cnt = 0, oe_cnt = 0, we_cnt = 0, dqoe_cnt = 0;
  logic [19:0] seen_addr = '0;
  logic [3:0]  seen_be = '0;
  logic [31:0] seen_dq = '0;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (rst) begin
      ce_cnt = 0; oe_cnt = 0; we_cnt = 0; dqoe_cnt = 0;
    end else begin
      chk("we_oe_overlap", {31'd0, (!sram_we_n && !sram_oe_n)}, 32'd0);
      chk("dq_oe_while_oe", {31'd0, (sram_dq_oe && !sram_oe_n)}, 32'd0);
      if (!sram_ce_n) begin ce_cnt++; seen_addr = sram_addr_o; seen_be = sram_be_n; end
      if (!sram_oe_n) oe_cnt++;
      if (!sram_we_n) we_cnt++;
      if (sram_dq_oe) begin dqoe_cnt++; seen_dq = sram_dq_o; end
      if (ack_o) begin
        n_assert++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_ack: ack_o=1 at cycle %0d, required no ack", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("ack_cycle", cyc, mon_e.ack_cyc);
          chk("data_o", data_o, mon_e.data_o);
          chk("ce_low_cycles", ce_cnt, mon_e.ce_cnt);
          chk("oe_low_cycles", oe_cnt, mon_e.oe_cnt);
          chk("we_low_cycles", we_cnt, mon_e.we_cnt);
          chk("dq_oe_cycles", dqoe_cnt, mon_e.dqoe_cnt);
          if (mon_e.ce_cnt > 0) begin
            chk("sram_addr", {12'd0, seen_addr}, {12'd0, mon_e.addr});
            chk("sram_be_n", {28'd0, seen_be}, {28'd0, mon_e.be_n});
          end
          if (mon_e.dqoe_cnt > 0) chk("sram_dq", seen_dq, mon_e.dq);
        end
        ce_cnt = 0; oe_cnt = 0; we_cnt = 0; dqoe_cnt = 0;
      end
    end
  end

  logic [31:0] last_rd = '0;
  int unsigned last_ack_cyc = 0;

  // Called at a negedge while the controller is idle; returns at the ack negedge.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] sel, input bit hold_ce, input bit scramble);
    exp_t        e;
    logic [19:0] wa;
    logic [31:0] w;
    int          lat;
    int          to;
    wa = addr[21:2];
    e.addr = wa;
    e.dq   = data;
    e.be_n = 4'b0000;
    e.ce_cnt = 0; e.oe_cnt = 0; e.we_cnt = 0; e.dqoe_cnt = 0;
    if (!we) begin
      lat = W + 2;
      e.data_o = ref_rd(wa);
      last_rd  = e.data_o;
      e.ce_cnt = W + 1;
      e.oe_cnt = W + 1;
    end else if (sel != 4'd0) begin
      lat = W + 3;
      e.data_o   = last_rd;
      e.ce_cnt   = W + 2;
      e.we_cnt   = W + 1;
      e.dqoe_cnt = W + 2;
      e.be_n     = ~sel;
      w = ref_rd(wa);
      if (sel[0]) w[7:0]   = data[7:0];
      if (sel[1]) w[15:8]  = data[15:8];
      if (sel[2]) w[23:16] = data[23:16];
      if (sel[3]) w[31:24] = data[31:24];
      ref_mem[wa] = w;
    end else begin
      lat = 1;
      e.data_o = last_rd;
    end
    e.ack_cyc = cyc + lat;
    exp_q.push_back(e);
    ce_i = 1'b1; we_i = we; addr_i = addr; data_i = data; sel_i = sel;
    @(posedge clk);
    #1;
    if (scramble) begin
      ce_i   = 1'($urandom_range(0, 1));
      we_i   = 1'($urandom_range(0, 1));
      addr_i = $urandom;
      data_i = $urandom;
      sel_i  = 4'($urandom_range(0, 15));
    end else if (!hold_ce) begin
      ce_i = 1'b0;
    end
    to = 0;
    @(negedge clk);
    while (!ack_o && to < 40) begin
      @(negedge clk);
      to++;
    end
    n_assert++;
    if (!ack_o) begin
      n_fail++;
      $display("FAIL ack_timeout: no ack_o within 40 cycles, required ack at cycle %0d", e.ack_cyc);
      exp_q.delete();
    end
    last_ack_cyc = cyc;
    if (!hold_ce) ce_i = 1'b0;
  endtask

  int unsigned ack_times[3];
  logic [31:0] orig;
  logic [31:0] ra;

  initial begin
    #12;
    chk("rst_data_o", data_o, 32'd0);
    chk("rst_ack_o", {31'd0, ack_o}, 32'd0);
    chk("rst_sram_addr", {12'd0, sram_addr_o}, 32'd0);
    chk("rst_sram_dq", sram_dq_o, 32'd0);
    chk("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("rst_ce_n", {31'd0, sram_ce_n}, 32'd1);
    chk("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
    chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rst_be_n", {28'd0, sram_be_n}, 32'hF);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // Read of a preloaded word.
    sram_mem[20'h00004] = 32'hDEADBEEF;
    ref_mem[20'h00004]  = 32'hDEADBEEF;
    do_txn(1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b0, 1'b0);
    chk("read_deadbeef", data_o, 32'hDEADBEEF);

    // Partial write: low half only.
    @(negedge clk);
    orig = init_word(20'h00008);
    do_txn(1'b1, 32'h0000_0020, 32'h12345678, 4'b0011, 1'b0, 1'b0);
    chk("sram_word8", sram_rd(20'h00008), {orig[31:16], 16'h5678});
    chk("data_o_held_after_write", data_o, 32'hDEADBEEF);

    // Empty byte-select write: no SRAM cycle, ack next cycle.
    @(negedge clk);
    do_txn(1'b1, 32'h0000_0030, 32'hCAFEF00D, 4'b0000, 1'b0, 1'b0);

    // Back-to-back reads with ce_i held high.
    @(negedge clk);
    do_txn(1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b1, 1'b0);
    ack_times[0] = last_ack_cyc;
    @(negedge clk);
    do_txn(1'b0, 32'h0000_0020, 32'h0, 4'h0, 1'b1, 1'b0);
    ack_times[1] = last_ack_cyc;
    @(negedge clk);
    do_txn(1'b0, 32'h0000_0044, 32'h0, 4'h0, 1'b1, 1'b0);
    ack_times[2] = last_ack_cyc;
    ce_i = 1'b0;
    chk("b2b_spacing_1", ack_times[1] - ack_times[0], W + 3);
    chk("b2b_spacing_2", ack_times[2] - ack_times[1], W + 3);

    // Reset during the second WRITE cycle; data equals current contents so memory stays known.
    @(negedge clk);
    ce_i = 1'b1; we_i = 1'b1; addr_i = 32'h0000_0024; data_i = ref_rd(20'h00009); sel_i = 4'hF;
    @(posedge clk);
    #1 ce_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_we_n", {31'd0, sram_we_n}, 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("mid_rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("mid_rst_ce_n", {31'd0, sram_ce_n}, 32'd1);
    chk("mid_rst_ack", {31'd0, ack_o}, 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    last_rd = 32'd0;
    repeat (6) @(negedge clk);

    // Upper address bits are ignored.
    do_txn(1'b0, 32'hFFC0_0010, 32'h0, 4'h0, 1'b0, 1'b0);
    chk("upper_addr_ignored", data_o, 32'hDEADBEEF);

    // Random traffic, with inputs scrambled while each operation is in flight.
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      ra = $urandom;
      ra[21:2] = ($urandom_range(0, 1) ? 20'hFFFF0 : 20'h00000) | 20'($urandom_range(0, 15));
      do_txn(1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom_range(0, 15)), 1'b0, 1'b1);
    end

    repeat (4) @(negedge clk);
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_expectations: %0d left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
